// File: rtl/outpad_serializer_if.sv
// outpad_serializer_if -- word-side handshake and pad-side outputs of
// outpad_serializer. The optional pad_parity wire exists only when
// LPM_OUTSER_PARITY_EN is defined.
interface outpad_serializer_if #(
  parameter int lpm_width = 8,
  parameter int lpm_ratio = 4
);
  logic [lpm_width*lpm_ratio-1:0] data;
  logic                           data_valid;
  logic                           data_ready;
  logic                           shift_en;
  logic [lpm_width-1:0]           pad_data;
  logic                           pad_valid;
  logic                           pad_first;
  logic                           pad_last;
  logic                           busy;
`ifdef LPM_OUTSER_PARITY_EN
  logic                           pad_parity;
`endif

  // Producer / pad consumer side
  modport master (
    output data, data_valid, shift_en,
    input  data_ready, pad_data, pad_valid, pad_first, pad_last, busy
`ifdef LPM_OUTSER_PARITY_EN
    , input pad_parity
`endif
  );

  // Serializer side
  modport slave (
    input  data, data_valid, shift_en,
    output data_ready, pad_data, pad_valid, pad_first, pad_last, busy
`ifdef LPM_OUTSER_PARITY_EN
    , output pad_parity
`endif
  );
endinterface

// File: rtl/outpad_serializer.sv
// outpad_serializer -- splits lpm_width*lpm_ratio-bit words into lpm_ratio
// slices, LSB slice first, one slice per shift_en cycle. A one-word pending
// buffer ahead of the shift register lets consecutive words stream with no
// idle slice. Optional feature macro: LPM_OUTSER_PARITY_EN adds a registered
// pad_parity output (XOR of pad_data bits, 0 while no slice is valid).
module outpad_serializer #(
  parameter int                   lpm_width = 8,
  parameter int                   lpm_ratio = 4,
  parameter logic [lpm_width-1:0] lpm_idle  = {lpm_width{1'b0}},
  parameter string                lpm_type  = "outpad_serializer"
) (
  input logic                clock,
  input logic                sclr,
  outpad_serializer_if.slave bus
);

  localparam int               WORD_W  = lpm_width * lpm_ratio;
  localparam int               CNT_W   = $clog2(lpm_ratio);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(lpm_ratio - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [WORD_W-1:0]    pend_r;
  logic                 pend_full_r;
  logic [WORD_W-1:0]    shreg_r;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [lpm_width-1:0] pad_data_r;
  logic                 pad_valid_r;
  logic                 pad_first_r;
  logic                 pad_last_r;

  logic                 take_s;
  logic                 load_s;
  logic                 step_s;
  logic                 drain_s;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [lpm_width-1:0] nxt_slice_s;

  function automatic logic [lpm_width-1:0] slice_f(input logic [WORD_W-1:0] word,
                                                   input logic [CNT_W-1:0]  idx);
    return word[int'(idx)*lpm_width +: lpm_width];
  endfunction

  function automatic logic parity_f(input logic [lpm_width-1:0] s);
    return ^s;
  endfunction

  // Input side accepts whenever pending is free; pad side events are mutually exclusive
  assign take_s      = bus.data_valid & ~pend_full_r;
  assign load_s      = bus.shift_en & pend_full_r & ((state_r == ST_IDLE) | (cnt_r == CNT_MAX));
  assign step_s      = bus.shift_en & (state_r == ST_SHIFT) & (cnt_r != CNT_MAX);
  assign drain_s     = bus.shift_en & (state_r == ST_SHIFT) & (cnt_r == CNT_MAX) & ~pend_full_r;
  assign cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign nxt_slice_s = load_s ? pend_r[lpm_width-1:0] : slice_f(shreg_r, cnt_nxt_s);

  assign bus.data_ready = ~pend_full_r & ~sclr;
  assign bus.busy       = pend_full_r | (state_r == ST_SHIFT);
  assign bus.pad_data   = pad_data_r;
  assign bus.pad_valid  = pad_valid_r;
  assign bus.pad_first  = pad_first_r;
  assign bus.pad_last   = pad_last_r;

  // Pending buffer: captures a word on each accepted transfer, empties when moved to the shifter
  always_ff @(posedge clock) begin
    if (sclr) begin
      pend_full_r <= 1'b0;
      pend_r      <= {WORD_W{1'b0}};
    end else if (take_s) begin
      pend_full_r <= 1'b1;
      pend_r      <= bus.data;
    end else if (load_s) begin
      pend_full_r <= 1'b0;
    end else begin
      pend_full_r <= pend_full_r;
    end
  end

  // Pad FSM: loads, steps and drains the shift register with registered pad outputs
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      shreg_r     <= {WORD_W{1'b0}};
      pad_data_r  <= lpm_idle;
      pad_valid_r <= 1'b0;
      pad_first_r <= 1'b0;
      pad_last_r  <= 1'b0;
    end else if (bus.shift_en) begin
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_r     <= ST_SHIFT;
            shreg_r     <= pend_r;
            cnt_r       <= {CNT_W{1'b0}};
            pad_data_r  <= nxt_slice_s;
            pad_valid_r <= 1'b1;
            pad_first_r <= 1'b1;
            pad_last_r  <= 1'b0;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (step_s) begin
            cnt_r       <= cnt_nxt_s;
            pad_data_r  <= nxt_slice_s;
            pad_first_r <= 1'b0;
            pad_last_r  <= (cnt_nxt_s == CNT_MAX);
          end else if (load_s) begin
            // Back-to-back reload: next word's slice 0 follows the last slice directly
            shreg_r     <= pend_r;
            cnt_r       <= {CNT_W{1'b0}};
            pad_data_r  <= nxt_slice_s;
            pad_valid_r <= 1'b1;
            pad_first_r <= 1'b1;
            pad_last_r  <= 1'b0;
          end else begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            pad_data_r  <= lpm_idle;
            pad_valid_r <= 1'b0;
            pad_first_r <= 1'b0;
            pad_last_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          pad_data_r  <= lpm_idle;
          pad_valid_r <= 1'b0;
          pad_first_r <= 1'b0;
          pad_last_r  <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

`ifdef LPM_OUTSER_PARITY_EN
  logic pad_parity_r;

  // Parity of the slice registered in the same edge as pad_data; zero when no slice is shown
  always_ff @(posedge clock) begin
    if (sclr) begin
      pad_parity_r <= 1'b0;
    end else if (load_s | step_s) begin
      pad_parity_r <= parity_f(nxt_slice_s);
    end else if (drain_s) begin
      pad_parity_r <= 1'b0;
    end else begin
      pad_parity_r <= pad_parity_r;
    end
  end

  assign bus.pad_parity = pad_parity_r;
`endif

endmodule
